// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts for SYNC_WORD in an MSB-first bit stream, then packs FRAME_WORDS payload words.
// Outputs are registered one edge after the completing bit. A word that completes while out_valid is high and out_ready is low is dropped, and overflow is set.
module serial_frame_receiver #(
  parameter int                   WORD_WIDE   = 8,
  parameter logic [WORD_WIDE-1:0] SYNC_WORD   = WORD_WIDE'(8'hA5),
  parameter int                   FRAME_WORDS = 4
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic                 enable,
  input  logic                 serial_in,
  input  logic                 out_ready,
  output logic [WORD_WIDE-1:0] out_data,
  output logic                 out_valid,
  output logic                 frame_done,
  output logic                 sync_locked,
  output logic                 overflow
);

  localparam int BCW = (WORD_WIDE > 1) ? $clog2(WORD_WIDE) : 1;
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(WORD_WIDE - 1);
  localparam logic [7:0]     LAST_WORD = 8'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [WORD_WIDE-1:0] hist, hist_n;
  logic [WORD_WIDE-1:0] shreg, shreg_n;
  logic [BCW-1:0]       bit_cnt, bit_cnt_n;
  logic [7:0]           word_cnt, word_cnt_n;
  logic [WORD_WIDE-1:0] data_n;
  logic                 valid_n;
  logic                 done_n;
  logic                 locked_n;
  logic                 ovf_n;
  logic [WORD_WIDE-1:0] hist_shift;
  logic [WORD_WIDE-1:0] word_shift;
  logic                 stalled;

  assign hist_shift = {hist[WORD_WIDE-2:0], serial_in};
  assign word_shift = {shreg[WORD_WIDE-2:0], serial_in};
  assign stalled    = out_valid && !out_ready;

  always_ff @(posedge clock) begin
    if (sclr) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    hist_n     = hist;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    data_n     = out_data;
    valid_n    = out_valid;
    done_n     = 1'b0;
    ovf_n      = overflow;

    // A handshake clears out_valid; a word loading on the same edge sets it again below.
    if (out_valid && out_ready) begin
      valid_n = 1'b0;
    end

    if (enable) begin
      case (state)
        HUNT: begin
          hist_n = hist_shift;
          if (hist_shift == SYNC_WORD) begin
            state_n    = RECV;
            bit_cnt_n  = '0;
            word_cnt_n = '0;
          end
        end
        RECV: begin
          shreg_n = word_shift;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n  = '0;
            word_cnt_n = word_cnt + 8'd1;
            if (stalled) begin
              ovf_n = 1'b1;
            end else begin
              data_n  = word_shift;
              valid_n = 1'b1;
            end
            // The next sync search starts from an empty history.
            if (word_cnt == LAST_WORD) begin
              state_n    = HUNT;
              hist_n     = '0;
              word_cnt_n = '0;
              done_n     = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + BCW'(1);
          end
        end
        default: state_n = HUNT;
      endcase
    end

    locked_n = (state_n == RECV);
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      hist        <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      sync_locked <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      hist        <= hist_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      word_cnt    <= word_cnt_n;
      out_data    <= data_n;
      out_valid   <= valid_n;
      frame_done  <= done_n;
      sync_locked <= locked_n;
      overflow    <= ovf_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: cycle model compared every cycle plus directed literal expectations.
module tb_serial_frame_receiver;

  localparam int W  = 8;
  localparam int FW = 2;

  logic         clock;
  logic         sclr;
  logic         enable;
  logic         serial_in;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         frame_done;
  logic         sync_locked;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  // Model state: plain integers describing what the receiver has seen so far.
  bit m_locked;
  int m_window, m_nbits, m_nwords, m_acc;
  bit m_valid, m_done, m_ovf;
  int m_data;

  logic [7:0] cap[$];
  int done_count;

  serial_frame_receiver #(
    .WORD_WIDE(W),
    .SYNC_WORD(8'hA5),
    .FRAME_WORDS(FW)
  ) dut (
    .clock(clock),
    .sclr(sclr),
    .enable(enable),
    .serial_in(serial_in),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .frame_done(frame_done),
    .sync_locked(sync_locked),
    .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    m_locked = 0; m_window = 0; m_nbits = 0; m_nwords = 0; m_acc = 0;
    m_valid = 0; m_done = 0; m_ovf = 0; m_data = 0;
  end

  always @(posedge clock) begin : model
    bit pv;
    if (sclr) begin
      m_locked = 0; m_window = 0; m_nbits = 0; m_nwords = 0; m_acc = 0;
      m_valid = 0; m_done = 0; m_ovf = 0; m_data = 0;
    end else begin
      pv = m_valid;
      m_done = 0;
      if (pv && out_ready) m_valid = 0;
      if (enable) begin
        if (!m_locked) begin
          m_window = ((m_window * 2) + int'(serial_in)) % (1 << W);
          if (m_window == 'hA5) begin
            m_locked = 1; m_nbits = 0; m_nwords = 0; m_acc = 0;
          end
        end else begin
          m_acc = ((m_acc * 2) + int'(serial_in)) % (1 << W);
          m_nbits++;
          if (m_nbits == W) begin
            m_nbits = 0;
            m_nwords++;
            if (pv && !out_ready) m_ovf = 1;
            else begin
              m_valid = 1;
              m_data = m_acc;
            end
            m_acc = 0;
            if (m_nwords == FW) begin
              m_done = 1; m_locked = 0; m_window = 0; m_nwords = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", 32'(out_data), 32'(m_data));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("sync_locked", 32'(sync_locked), 32'(m_locked));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (out_valid === 1'b1 && out_ready && !sclr) cap.push_back(out_data);
      if (frame_done === 1'b1) done_count++;
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      sclr = 1'b1; enable = 1'b1; serial_in = 1'($urandom_range(0, 1));
    end
    @(posedge clock); #1;
    sclr = 1'b0; enable = 1'b0;
  endtask

  task automatic send_n(input logic [31:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      @(posedge clock); #1;
      enable = 1'b1; serial_in = v[i];
      if (gap) begin
        @(posedge clock); #1;
        enable = 1'b0; serial_in = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      enable = 1'b0; serial_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_words(input string name, input int n, input logic [7:0] w0, input logic [7:0] w1);
    check({name, "_count"}, 32'(cap.size()), 32'(n));
    if (n > 0 && cap.size() > 0) check({name, "_w0"}, 32'(cap[0]), 32'(w0));
    if (n > 1 && cap.size() > 1) check({name, "_w1"}, 32'(cap[1]), 32'(w1));
  endtask

  task automatic check_zero(input string name);
    @(negedge clock);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_data"}, 32'(out_data), 32'd0);
    check({name, "_done"}, 32'(frame_done), 32'd0);
    check({name, "_locked"}, 32'(sync_locked), 32'd0);
    check({name, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  task automatic start_case();
    cap.delete();
    done_count = 0;
  endtask

  initial begin
    sclr = 1'b1; enable = 1'b1; serial_in = 1'b0; out_ready = 1'b0;
    done_count = 0;

    // Reset with live stimulus.
    do_reset(2);
    checking = 1;
    check_zero("reset");

    // Single frame.
    start_case();
    out_ready = 1'b1;
    send_n(32'hA5, 8, 0);
    send_n(32'h12, 8, 0);
    send_n(32'h34, 8, 0);
    idle(4);
    @(negedge clock);
    check_words("single", 2, 8'h12, 8'h34);
    check("single_done_count", 32'(done_count), 32'd1);
    check("single_unlocked", 32'(sync_locked), 32'd0);

    // False sync, then a true one; sync pattern inside payload is data.
    start_case();
    send_n(32'b1010010, 7, 0);
    send_n(32'b0, 1, 0);
    idle(2);
    @(negedge clock);
    check("false_sync_locked", 32'(sync_locked), 32'd0);
    send_n(32'hA5, 8, 0);
    idle(1);
    @(negedge clock);
    check("true_sync_locked", 32'(sync_locked), 32'd1);
    send_n(32'hA5, 8, 0);
    send_n(32'h5A, 8, 0);
    idle(4);
    @(negedge clock);
    check_words("payload_sync", 2, 8'hA5, 8'h5A);
    check("payload_sync_done", 32'(done_count), 32'd1);

    // Backpressure: second word is dropped.
    start_case();
    @(posedge clock); #1; out_ready = 1'b0;
    send_n(32'hA5, 8, 0);
    send_n(32'h11, 8, 0);
    send_n(32'h22, 8, 0);
    idle(3);
    @(negedge clock);
    check("bp_data_held", 32'(out_data), 32'h11);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_overflow", 32'(overflow), 32'd1);
    @(posedge clock); #1; out_ready = 1'b1;
    idle(2);
    @(negedge clock);
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_overflow_sticky", 32'(overflow), 32'd1);
    check_words("bp", 1, 8'h11, 8'h00);

    // Gapped enable after clearing overflow.
    do_reset(1);
    start_case();
    send_n(32'hA5, 8, 1);
    send_n(32'h12, 8, 1);
    send_n(32'h34, 8, 1);
    idle(4);
    @(negedge clock);
    check_words("gapped", 2, 8'h12, 8'h34);
    check("gapped_done_count", 32'(done_count), 32'd1);
    check("gapped_overflow", 32'(overflow), 32'd0);

    // Reset in the middle of a payload word, then a clean frame.
    start_case();
    send_n(32'hA5, 8, 0);
    send_n(32'b10110, 5, 0);
    do_reset(1);
    check_zero("midreset");
    send_n(32'hA5, 8, 0);
    send_n(32'h12, 8, 0);
    send_n(32'h34, 8, 0);
    idle(4);
    @(negedge clock);
    check_words("after_reset", 2, 8'h12, 8'h34);
    check("after_reset_done", 32'(done_count), 32'd1);

    checking = 0;
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 The block SHALL have parameter WORD_WIDE, default 8, bits per received word.
REQ-002 The block SHALL have parameter SYNC_WORD, default 8'hA5, the WORD_WIDE-bit frame header pattern.
REQ-003 The block SHALL have parameter FRAME_WORDS, default 4, payload words per frame (range 1..255).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port sclr, input, 1, the reset; it is synchronous and active-high.
REQ-006 The block SHALL have port enable, input, 1, bit strobe; serial_in is sampled only when enable=1.
REQ-007 The block SHALL have port serial_in, input, 1, the MSB-first bit stream from the upstream left-shift register shiftout.
REQ-008 The block SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-009 The block SHALL have port out_data, output, WORD_WIDE, the assembled payload word.
REQ-010 The block SHALL have port out_valid, output, 1, out_data holds an unconsumed word.
REQ-011 The block SHALL have port frame_done, output, 1, one-cycle pulse at the end of a frame.
REQ-012 The block SHALL have port sync_locked, output, 1, high while in the RECV state.
REQ-013 The block SHALL have port overflow, output, 1, sticky flag: a payload word was dropped.

Function
REQ-014 The block SHALL implement two states, HUNT and RECV; all outputs SHALL be registered.
REQ-015 In HUNT, each enabled bit SHALL shift into a WORD_WIDE-bit history register at the LSB (hist <= {hist[WORD_WIDE-2:0], serial_in}).
REQ-016 In HUNT, when the post-shift history equals SYNC_WORD, the block SHALL enter RECV at that edge, with the bit count and word count cleared.
REQ-017 The block SHALL detect sync in HUNT only; SYNC_WORD patterns inside payload SHALL be treated as data.
REQ-018 In RECV, each enabled bit SHALL shift into the word register, MSB-first; enable=0 cycles SHALL hold all counters and registers.
REQ-019 On the edge sampling bit WORD_WIDE of a word, if out_valid=0 or (out_valid and out_ready), the block SHALL load out_data and set out_valid=1, visible the next cycle.
REQ-020 If out_valid=1 and out_ready=0 at word completion, the block SHALL drop the new word, keep out_data unchanged and set overflow=1.
REQ-021 out_valid SHALL clear on the edge where out_valid and out_ready are both 1, unless a new word loads at that same edge.
REQ-022 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 The word count SHALL increment on every completed word, whether stored or dropped.
REQ-024 When word FRAME_WORDS completes, the block SHALL pulse frame_done for exactly one cycle, return to HUNT and clear the history to 0.
REQ-025 The first bit after frame end SHALL be the first bit of the next sync search; history bits SHALL NOT carry over across frames.
REQ-026 A pending out_valid SHALL survive the return to HUNT until it is consumed.
REQ-027 overflow SHALL remain 1 until sclr.

Reset
REQ-028 sclr=1 at a rising edge SHALL set state=HUNT, history=0, bit and word counts=0, out_data=0, out_valid=0, frame_done=0, sync_locked=0 and overflow=0.
REQ-029 sclr SHALL override enable, out_ready and all in-progress activity, including a word completing at that edge and a reset during RECV.

Verification
REQ-030 Reset: sclr for 2 cycles with random serial_in and enable=1 -> all outputs 0, state HUNT.
REQ-031 Single frame: FRAME_WORDS=2, out_ready=1, bits 10100101 then 00010010 then 00110100 -> out_valid with 8'h12, then 8'h34, frame_done pulsed once, sync_locked back to 0.
REQ-032 False sync: stream 1010010 followed by 0 (history never equal to A5) -> sync_locked stays 0; then 1 completing ...0100101 after a prior 1 -> lock.
REQ-033 Backpressure: out_ready=0 across two words 8'h11 and 8'h22 -> out_data=8'h11 held, overflow=1; out_ready=1 -> 8'h11 consumed, out_valid=0.
REQ-034 Gapped enable: same frame as REQ-031 with enable=0 on alternate cycles -> identical words and frame_done, with timing stretched.
REQ-035 Mid-frame reset: sclr after 5 payload bits -> all outputs 0, and a following full frame decodes correctly.
